// File: rtl/alu_arb.sv
// Two-requester round-robin front end for a single shared combinational ALU.
// One operation in flight: accept in IDLE, capture the result in EXEC, respond in RESP.
module alu_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_alu_op,
  input  logic [3:0]  req0_func_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_alu_op,
  input  logic [3:0]  req1_func_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [1:0]  alu_op_o,
  output logic [3:0]  func_op_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  input  logic [31:0] alu_res_i,
  input  logic        alu_zero_i,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_zero,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last;      // 1: requester 1 was granted most recently
  logic        r_winner;    // requester owning the operation in flight
  logic [1:0]  r_alu_op;
  logic [3:0]  r_func_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_rsp_data;
  logic        r_rsp_zero;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_accept;

  // NOTE: every signal assigned in this always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        // Grants are gated by rst so nothing is offered while the block is held in reset.
        if (!rst) begin
          if (req0_valid && (!req1_valid || r_last)) begin
            w_grant0 = 1'b1;
          end else if (req1_valid) begin
            w_grant1 = 1'b1;
          end
        end
        if (w_grant0 || w_grant1) begin
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept = w_grant0 | w_grant1;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_last     <= 1'b1;
      r_winner   <= 1'b0;
      r_alu_op   <= '0;
      r_func_op  <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_rsp_data <= '0;
      r_rsp_zero <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_winner  <= w_grant1;
        r_last    <= w_grant1;
        r_alu_op  <= w_grant1 ? req1_alu_op  : req0_alu_op;
        r_func_op <= w_grant1 ? req1_func_op : req0_func_op;
        r_a       <= w_grant1 ? req1_a       : req0_a;
        r_b       <= w_grant1 ? req1_b       : req0_b;
      end
      if (r_state == S_EXEC) begin
        r_rsp_data <= alu_res_i;
        r_rsp_zero <= alu_zero_i;
      end
    end
  end

  // The ALU sees only registered operands, never the live request buses.
  assign alu_op_o   = r_alu_op;
  assign func_op_o  = r_func_op;
  assign alu_a_o    = r_a;
  assign alu_b_o    = r_b;

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign rsp0_valid = (r_state == S_RESP) && !r_winner;
  assign rsp1_valid = (r_state == S_RESP) &&  r_winner;
  assign rsp_data   = r_rsp_data;
  assign rsp_zero   = r_rsp_zero;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_arb.sv
// Self-checking bench for alu_arb: a scoreboard of accepted operations checked against
// responses, plus directed arbitration, latency, hold and reset-abort scenarios.
module tb_alu_arb;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_alu_op, req1_alu_op;
  logic [3:0]  req0_func_op, req1_func_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  alu_op_o;
  logic [3:0]  func_op_o;
  logic [31:0] alu_a_o, alu_b_o;
  logic [31:0] alu_res_i;
  logic        alu_zero_i;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp_data;
  logic        rsp_zero;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic        port;
    logic [31:0] data;
    logic        zero;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  alu_arb dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_alu_op  (req0_alu_op),
    .req0_func_op (req0_func_op),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_alu_op  (req1_alu_op),
    .req1_func_op (req1_func_op),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .alu_op_o     (alu_op_o),
    .func_op_o    (func_op_o),
    .alu_a_o      (alu_a_o),
    .alu_b_o      (alu_b_o),
    .alu_res_i    (alu_res_i),
    .alu_zero_i   (alu_zero_i),
    .rsp0_valid   (rsp0_valid),
    .rsp1_valid   (rsp1_valid),
    .rsp_data     (rsp_data),
    .rsp_zero     (rsp_zero),
    .busy         (busy)
  );

  // Stand-in for the shared ALU: 00 add, 01 sub, 10 decoded by func_op.
  function automatic logic [31:0] alu_model(input logic [1:0] op, input logic [3:0] fn,
                                            input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'b00: return a + b;
      2'b01: return a - b;
      2'b10: begin
        case (fn)
          4'b0000: return a + b;
          4'b1000: return a - b;
          4'b0111: return a & b;
          default: return a ^ b;
        endcase
      end
      default: return a | b;
    endcase
  endfunction

  assign alu_res_i  = alu_model(alu_op_o, func_op_o, alu_a_o, alu_b_o);
  assign alu_zero_i = (alu_res_i == 32'd0);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic        prev_rst = 1'b1;
  logic        ops_pending = 1'b0;
  logic [5:0]  exp_ctrl, prev_ctrl;
  logic [31:0] exp_a, exp_b, prev_a, prev_b;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      ops_pending = 1'b0;
    end else begin
      check("ready_excl", 32'(req0_ready & req1_ready), 0);
      if (busy) check("ready_busy", 32'(req0_ready | req1_ready), 0);

      if (ops_pending) begin
        check("ops_ctrl", 32'({alu_op_o, func_op_o}), 32'(exp_ctrl));
        check("ops_a", alu_a_o, exp_a);
        check("ops_b", alu_b_o, exp_b);
        ops_pending = 1'b0;
      end else if (!prev_rst) begin
        check("iso_ctrl", 32'({alu_op_o, func_op_o}), 32'(prev_ctrl));
        check("iso_a", alu_a_o, prev_a);
        check("iso_b", alu_b_o, prev_b);
      end

      if (req0_ready || req1_ready) begin
        exp_t e;
        e.port   = req1_ready;
        exp_ctrl = req1_ready ? {req1_alu_op, req1_func_op} : {req0_alu_op, req0_func_op};
        exp_a    = req1_ready ? req1_a : req0_a;
        exp_b    = req1_ready ? req1_b : req0_b;
        e.data   = alu_model(exp_ctrl[5:4], exp_ctrl[3:0], exp_a, exp_b);
        e.zero   = (e.data == 32'd0);
        e.cyc    = cyc + 2;
        sb.push_back(e);
        ops_pending = 1'b1;
      end

      if (rsp0_valid || rsp1_valid) begin
        check("rsp_excl", 32'(rsp0_valid & rsp1_valid), 0);
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'(rsp1_valid), 32'(!rsp0_valid));
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_port", 32'(rsp1_valid), 32'(e.port));
          check("rsp_data", rsp_data, e.data);
          check("rsp_zero", 32'(rsp_zero), 32'(e.zero));
          check("rsp_cyc", cyc, e.cyc);
        end
      end
    end
    prev_rst  = rst;
    prev_ctrl = {alu_op_o, func_op_o};
    prev_a    = alu_a_o;
    prev_b    = alu_b_o;
  end

  // ---------------- stimulus helpers ----------------
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic port, input logic v, input logic [1:0] op,
                         input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
    if (port) begin
      req1_valid = v; req1_alu_op = op; req1_func_op = fn; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_alu_op = op; req0_func_op = fn; req0_a = a; req0_b = b;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) next();
    rst = 1'b0;
  endtask

  // Raise valid, wait (bounded) for ready, then drop valid in the following cycle.
  task automatic issue(input logic port, input logic [1:0] op, input logic [3:0] fn,
                       input logic [31:0] a, input logic [31:0] b, output int t);
    int start;
    start = cyc;
    t = -1;
    set_req(port, 1'b1, op, fn, a, b);
    for (int i = 0; i < 8 && t < 0; i++) begin
      @(negedge clk);
      if (port ? req1_ready : req0_ready) t = cyc;
      next();
    end
    check("issue_ready_cyc", t, start);
    if (port) req1_valid = 1'b0;
    else      req0_valid = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int t;
    int tg[3];
    logic who[3];
    logic found;

    rst = 1'b1;
    set_req(1'b0, 1'b1, 2'b00, 4'h0, 32'd1, 32'd1);
    set_req(1'b1, 1'b1, 2'b00, 4'h0, 32'd2, 32'd2);

    // Reset state, with both requesters pushing.
    next(); next();
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready0", 32'(req0_ready), 0);
    check("rst_ready1", 32'(req1_ready), 0);
    check("rst_rsp0", 32'(rsp0_valid), 0);
    check("rst_rsp1", 32'(rsp1_valid), 0);
    check("rst_data", rsp_data, 0);
    check("rst_zero", 32'(rsp_zero), 0);
    check("rst_ops", alu_a_o | alu_b_o | 32'({alu_op_o, func_op_o}), 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    next();
    rst = 1'b0;
    next();

    // Single op: 5 + 7.
    issue(1'b0, 2'b10, 4'b0000, 32'd5, 32'd7, t);
    next();
    @(negedge clk);
    check("single_rsp0", 32'(rsp0_valid), 1);
    check("single_rsp1", 32'(rsp1_valid), 0);
    check("single_data", rsp_data, 32'd12);
    check("single_zero", 32'(rsp_zero), 0);
    next();

    // Simultaneous held requests after reset: req0, req1, req0 three cycles apart.
    do_reset();
    set_req(1'b0, 1'b1, 2'b00, 4'h0, 32'd1, 32'd2);
    set_req(1'b1, 1'b1, 2'b01, 4'h0, 32'd10, 32'd3);
    for (int g = 0; g < 3; g++) begin
      found = 1'b0;
      tg[g] = -1;
      who[g] = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) begin
          found  = 1'b1;
          who[g] = req1_ready;
          tg[g]  = cyc;
        end
        next();
      end
      check("sim_found", 32'(found), 1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("sim_who0", 32'(who[0]), 0);
    check("sim_who1", 32'(who[1]), 1);
    check("sim_who2", 32'(who[2]), 0);
    check("sim_gap1", tg[1] - tg[0], 3);
    check("sim_gap2", tg[2] - tg[0], 6);
    next(); next();

    // Zero flag: 9 - 9 from requester 1.
    issue(1'b1, 2'b01, 4'h0, 32'd9, 32'd9, t);
    next();
    @(negedge clk);
    check("zero_rsp1", 32'(rsp1_valid), 1);
    check("zero_rsp0", 32'(rsp0_valid), 0);
    check("zero_data", rsp_data, 0);
    check("zero_flag", 32'(rsp_zero), 1);
    next();

    // Request from req1 arriving while busy is held off until the next IDLE.
    issue(1'b0, 2'b00, 4'h0, 32'd100, 32'd23, t);
    set_req(1'b1, 1'b1, 2'b00, 4'h0, 32'd4, 32'd4);
    @(negedge clk);
    check("held_ready_t1", 32'(req1_ready), 0);
    next();
    @(negedge clk);
    check("held_ready_t2", 32'(req1_ready), 0);
    next();
    @(negedge clk);
    check("held_ready_t3", 32'(req1_ready), 1);
    check("held_data_t3", rsp_data, 32'd123);
    next();
    req1_valid = 1'b0;
    @(negedge clk);
    check("held_data_t4", rsp_data, 32'd123);
    next();
    @(negedge clk);
    check("held_rsp1_t5", 32'(rsp1_valid), 1);
    check("held_data_t5", rsp_data, 32'd8);
    next();

    // Reset during EXEC aborts the op and restores req0 priority.
    issue(1'b0, 2'b00, 4'h0, 32'd3, 32'd4, t);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy_exec", 32'(busy), 1);
    next();
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_data", rsp_data, 0);
    check("abort_zero", 32'(rsp_zero), 0);
    check("abort_ops_a", alu_a_o, 0);
    check("abort_rsp", 32'(rsp0_valid | rsp1_valid), 0);
    next();
    @(negedge clk);
    check("abort_rsp_late", 32'(rsp0_valid | rsp1_valid), 0);
    next();
    set_req(1'b0, 1'b1, 2'b10, 4'b0111, 32'hF0F0, 32'h0FF0);
    set_req(1'b1, 1'b1, 2'b10, 4'b0001, 32'h1234, 32'h1234);
    @(negedge clk);
    check("abort_next_r0", 32'(req0_ready), 1);
    check("abort_next_r1", 32'(req1_ready), 0);
    next();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (4) next();

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
